// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg : shared fetch constants, FSM state encoding and buffer entry type
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_RESET = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_FULL  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo : small FIFO of {pc, instr} entries with synchronous flush
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  fetch_entry_t     wdata,
  output fetch_entry_t     rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic             clear;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign clear   = rst || flush;
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit : credit-based instruction fetch with epoch-tagged redirect flush
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_rd_en_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);

  localparam int          CNT_W       = $clog2(DEPTH + 1);
  localparam int          OCC_W       = CNT_W + 1;
  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

  fetch_state_e     state;
  fetch_state_e     state_next;
  logic [31:0]      fetch_pc;
  logic             epoch;
  logic             inflight;
  logic             inflight_epoch;
  logic [31:0]      inflight_pc;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             handshake;
  logic             push;
  logic             credit_ok;
  logic             issue;
  logic [OCC_W-1:0] occupancy;

  // A response is kept only if its epoch survived every redirect since issue.
  assign push       = inflight && (inflight_epoch == epoch) && !redirect_i && !rst_i;
  assign push_entry = '{pc: inflight_pc, instr: imem_rdata_i};
  assign handshake  = instr_valid_o && instr_ready_i;
  assign occupancy  = OCC_W'(fifo_count) + OCC_W'(inflight) - OCC_W'(handshake);
  assign credit_ok  = occupancy < OCC_W'(DEPTH);
  assign issue      = (state == FETCH_RUN) && credit_ok && !redirect_i && !rst_i;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .flush (redirect_i),
    .push  (push),
    .pop   (handshake),
    .wdata (push_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // FULL is only entered when no credit exists even with this cycle's pop.
  always_comb begin
    state_next = state;
    unique case (state)
      FETCH_RESET: state_next = FETCH_RUN;
      FETCH_RUN:   if (!redirect_i && !credit_ok) state_next = FETCH_FULL;
      FETCH_FULL:  if (redirect_i || handshake) state_next = FETCH_RUN;
      default:     state_next = FETCH_RESET;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= FETCH_RESET;
      fetch_pc       <= RESET_PC_AL;
      epoch          <= 1'b0;
      inflight       <= 1'b0;
      inflight_epoch <= 1'b0;
      inflight_pc    <= RESET_PC_AL;
    end else begin
      state          <= state_next;
      inflight       <= issue;
      inflight_epoch <= epoch;
      if (issue) inflight_pc <= fetch_pc;
      if (redirect_i) begin
        epoch    <= ~epoch;
        fetch_pc <= {redirect_pc_i[31:2], 2'b00};
      end else if (issue) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
    end
  end

  assign imem_rd_en_o  = issue;
  assign imem_addr_o   = rst_i ? RESET_PC_AL : fetch_pc;
  assign instr_valid_o = !fifo_empty && !redirect_i && !rst_i;
  assign instr_o       = (rst_i || fifo_empty) ? NOP_INSTR : head.instr;
  assign pc_o          = (rst_i || fifo_empty) ? RESET_PC_AL : head.pc;
  assign pc_plus4_o    = pc_o + 32'd4;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit : directed self-checking bench for fetch_unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_rd_en_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i = 32'hDEAD_BEEF;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;

  int compared   = 0;
  int mismatched = 0;
  int reads      = 0;
  int handshakes = 0;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_rd_en_o  (imem_rd_en_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .pc_plus4_o    (pc_plus4_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory returns the word address as data; garbage when not read.
  always @(posedge clk_i) begin
    imem_rdata_i <= imem_rd_en_o ? imem_addr_o : 32'hDEAD_BEEF;
    if (imem_rd_en_o) reads <= reads + 1;
    if (instr_valid_o && instr_ready_i) handshakes <= handshakes + 1;
  end

  task automatic adv(input logic rst, input logic rdy, input logic rd, input logic [31:0] rpc);
    @(negedge clk_i);
    rst_i         = rst;
    instr_ready_i = rdy;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    int r0;
    logic found;

    rst_i = 1'b1; instr_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    // Reset must win over a concurrent redirect and ready.
    repeat (3) adv(1'b1, 1'b1, 1'b1, 32'h0000_0040);
    chk1 ("rst_valid", instr_valid_o, 1'b0);
    chk1 ("rst_rd_en", imem_rd_en_o, 1'b0);
    chk32("rst_addr",  imem_addr_o, 32'h0);
    chk32("rst_instr", instr_o, 32'h0000_0013);
    chk32("rst_pc",    pc_o, 32'h0);

    // Streaming with ready held high.
    adv(1'b0, 1'b1, 1'b0, '0);                       // cycle 0: RESET state
    chk1 ("c0_rd_en", imem_rd_en_o, 1'b0);
    chk1 ("c0_valid", instr_valid_o, 1'b0);
    adv(1'b0, 1'b1, 1'b0, '0);                       // cycle 1
    chk1 ("c1_rd_en", imem_rd_en_o, 1'b1);
    chk32("c1_addr",  imem_addr_o, 32'h0);
    chk1 ("c1_valid", instr_valid_o, 1'b0);
    adv(1'b0, 1'b1, 1'b0, '0);                       // cycle 2
    chk32("c2_addr",  imem_addr_o, 32'h4);
    chk1 ("c2_valid", instr_valid_o, 1'b0);
    adv(1'b0, 1'b1, 1'b0, '0);                       // cycle 3
    chk1 ("c3_valid", instr_valid_o, 1'b1);
    chk32("c3_pc",    pc_o, 32'h0);
    chk32("c3_instr", instr_o, 32'h0);
    chk32("c3_pc4",   pc_plus4_o, 32'h4);
    chk32("c3_addr",  imem_addr_o, 32'h8);
    for (int k = 4; k <= 8; k++) begin
      adv(1'b0, 1'b1, 1'b0, '0);
      chk1 ("stream_valid", instr_valid_o, 1'b1);
      chk32("stream_pc",    pc_o, 32'(4 * (k - 3)));
      chk32("stream_instr", instr_o, 32'(4 * (k - 3)));
    end

    // Redirect with a read in flight and ready high in the same cycle.
    adv(1'b0, 1'b1, 1'b1, 32'h0000_0103);            // cycle 9
    hs0 = handshakes;
    chk1 ("redir_valid", instr_valid_o, 1'b0);
    chk1 ("redir_rd_en", imem_rd_en_o, 1'b0);
    adv(1'b0, 1'b1, 1'b0, '0);                       // cycle 10
    chk32("redir_no_xfer", 32'(handshakes), 32'(hs0));
    chk1 ("redir_rd1",     imem_rd_en_o, 1'b1);
    chk32("redir_addr1",   imem_addr_o, 32'h100);
    chk1 ("redir_drop",    instr_valid_o, 1'b0);
    adv(1'b0, 1'b1, 1'b0, '0);                       // cycle 11
    chk32("redir_addr2",   imem_addr_o, 32'h104);
    chk1 ("redir_valid2",  instr_valid_o, 1'b0);
    adv(1'b0, 1'b1, 1'b0, '0);                       // cycle 12
    chk1 ("redir_valid3",  instr_valid_o, 1'b1);
    chk32("redir_pc3",     pc_o, 32'h100);
    chk32("redir_instr3",  instr_o, 32'h100);
    adv(1'b0, 1'b1, 1'b0, '0);                       // cycle 13
    chk32("redir_pc4",     pc_o, 32'h104);

    // Redirect near the top of the address space and wrap.
    adv(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);            // cycle 14
    chk1 ("wrap_redir_valid", instr_valid_o, 1'b0);
    adv(1'b0, 1'b1, 1'b0, '0);                       // cycle 15
    chk32("wrap_addr0", imem_addr_o, 32'hFFFF_FFF8);
    adv(1'b0, 1'b1, 1'b0, '0);                       // cycle 16
    chk32("wrap_addr1", imem_addr_o, 32'hFFFF_FFFC);
    adv(1'b0, 1'b1, 1'b0, '0);                       // cycle 17
    chk32("wrap_pc0",   pc_o, 32'hFFFF_FFF8);
    chk32("wrap_pc4_0", pc_plus4_o, 32'hFFFF_FFFC);
    chk1 ("wrap_rd2",   imem_rd_en_o, 1'b1);
    chk32("wrap_addr2", imem_addr_o, 32'h0);
    adv(1'b0, 1'b1, 1'b0, '0);                       // cycle 18
    chk32("wrap_pc1",   pc_o, 32'hFFFF_FFFC);
    chk32("wrap_pc4_1", pc_plus4_o, 32'h0);
    adv(1'b0, 1'b1, 1'b0, '0);                       // cycle 19
    chk32("wrap_pc2",   pc_o, 32'h0);
    chk32("wrap_pc4_2", pc_plus4_o, 32'h4);
    chk1 ("wrap_valid2", instr_valid_o, 1'b1);

    // Reset mid-stream with a read in flight, redirect and ready also high.
    adv(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    chk1 ("mrst_valid", instr_valid_o, 1'b0);
    chk1 ("mrst_rd_en", imem_rd_en_o, 1'b0);
    chk32("mrst_addr",  imem_addr_o, 32'h0);
    chk32("mrst_instr", instr_o, 32'h0000_0013);
    chk32("mrst_pc",    pc_o, 32'h0);
    adv(1'b0, 1'b0, 1'b0, '0);                       // RESET cycle, ready low from here
    r0 = reads;
    chk1 ("mrst_c0_rd",    imem_rd_en_o, 1'b0);
    chk1 ("mrst_c0_valid", instr_valid_o, 1'b0);
    adv(1'b0, 1'b0, 1'b0, '0);
    chk1 ("mrst_c1_rd",    imem_rd_en_o, 1'b1);
    chk32("mrst_c1_addr",  imem_addr_o, 32'h0);
    adv(1'b0, 1'b0, 1'b0, '0);
    chk1 ("mrst_c2_valid", instr_valid_o, 1'b0);
    adv(1'b0, 1'b0, 1'b0, '0);
    chk1 ("mrst_c3_valid", instr_valid_o, 1'b1);
    chk32("mrst_c3_pc",    pc_o, 32'h0);
    chk32("mrst_c3_instr", instr_o, 32'h0);

    // Stall: head must hold at pc 0 while ready is low.
    for (int i = 0; i < 9; i++) begin
      adv(1'b0, 1'b0, 1'b0, '0);
      chk1 ("stall_valid", instr_valid_o, 1'b1);
      chk32("stall_pc",    pc_o, 32'h0);
      chk32("stall_instr", instr_o, 32'h0);
    end
    chk1("stall_reads_le2", (reads - r0) <= 2, 1'b1);
    adv(1'b0, 1'b1, 1'b0, '0);
    chk1 ("rel_valid0", instr_valid_o, 1'b1);
    chk32("rel_pc0",    pc_o, 32'h0);
    adv(1'b0, 1'b1, 1'b0, '0);
    chk1 ("rel_valid1", instr_valid_o, 1'b1);
    chk32("rel_pc1",    pc_o, 32'h4);
    chk32("rel_instr1", instr_o, 32'h4);
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      adv(1'b0, 1'b1, 1'b0, '0);
      found = instr_valid_o;
    end
    chk1 ("rel_found2", found, 1'b1);
    chk32("rel_pc2",    pc_o, 32'h8);
    adv(1'b0, 1'b1, 1'b0, '0);
    chk1 ("rel_valid3", instr_valid_o, 1'b1);
    chk32("rel_pc3",    pc_o, 32'hC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
